// File: rtl/data_mem_responder.sv
// Single-port data memory slave with a fixed request-to-response latency.
// Decodes RV32I load/store sizes, checks alignment and range, and reports errors.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          req_ready_next, resp_valid_next, resp_err_next;
  logic [31:0]   resp_rdata_next;
  logic          cap_load_c;

  logic          cap_we;
  logic [31:0]   cap_addr, cap_wdata;
  logic [2:0]    cap_funct3;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx_c;
  logic [31:0]   word_c, load_c, wr_word_c;
  logic [4:0]    bsh_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic          range_err_c, size_err_c, err_c, finish_c;

  assign idx_c       = cap_addr[AW+1:2];
  assign word_c      = mem[idx_c];
  assign bsh_c       = {cap_addr[1:0], 3'b000};
  assign byte_c      = word_c[bsh_c +: 8];
  assign half_c      = cap_addr[1] ? word_c[31:16] : word_c[15:0];
  assign range_err_c = |cap_addr[31:AW+2];
  assign err_c       = range_err_c | size_err_c;
  assign finish_c    = (state == BUSY) && (cnt == CW'(LATENCY));

  // Size/sign decode, misalignment check, load extension and store lane merge
  always_comb begin
    size_err_c = 1'b0;
    load_c     = 32'h0;
    wr_word_c  = word_c;
    case (cap_funct3)
      3'b000: begin
        load_c = {{24{byte_c[7]}}, byte_c};
        wr_word_c[bsh_c +: 8] = cap_wdata[7:0];
      end
      3'b001: begin
        size_err_c = cap_addr[0];
        load_c     = {{16{half_c[15]}}, half_c};
        if (cap_addr[1]) wr_word_c[31:16] = cap_wdata[15:0];
        else             wr_word_c[15:0]  = cap_wdata[15:0];
      end
      3'b010: begin
        size_err_c = |cap_addr[1:0];
        load_c     = word_c;
        wr_word_c  = cap_wdata;
      end
      3'b100: begin
        size_err_c = cap_we;
        load_c     = {24'h0, byte_c};
      end
      3'b101: begin
        size_err_c = cap_we | cap_addr[0];
        load_c     = {16'h0, half_c};
      end
      default: size_err_c = 1'b1;
    endcase
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    resp_rdata_next = resp_rdata;
    resp_err_next   = resp_err;
    cap_load_c      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = BUSY;
          cnt_next   = CW'(1);
          cap_load_c = 1'b1;
        end
      end
      BUSY: begin
        if (finish_c) begin
          state_next      = RESP;
          resp_err_next   = err_c;
          resp_rdata_next = (err_c || cap_we) ? 32'h0 : load_c;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next      = IDLE;
          resp_err_next   = 1'b0;
          resp_rdata_next = 32'h0;
        end
      end
      default: state_next = IDLE;
    endcase
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_ready  <= req_ready_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
    end
  end

  // Request copies are held through BUSY/RESP so input changes are ignored
  always_ff @(posedge clk) begin
    if (cap_load_c) begin
      cap_we     <= req_we;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
      cap_funct3 <= req_funct3;
    end
  end

  // Store commits on the edge entering RESP; contents are not reset
  always_ff @(posedge clk) begin
    if (!reset && finish_c && cap_we && !err_c) mem[idx_c] <= wr_word_c;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at default DEPTH=256, LATENCY=2.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_funct3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
  endtask

  // Issue one request from IDLE (called at a negedge) and check its response timing/data
  task automatic transact(input string name, input vec_t v);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    drive(v.we, v.addr, v.wdata, v.f3);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " valid@k+1"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    check({name, " valid@k+2"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    check({name, " valid@k+3"}, 32'(resp_valid), 32'd1);
    check({name, " rdata"}, resp_rdata, v.exp_rdata);
    check({name, " err"}, 32'(resp_err), 32'(v.exp_err));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, " valid after hs"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b010);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //            we    addr          wdata          f3      rdata          err
    vecs.push_back('{1'b1, 32'h10,  32'h12345678, 3'b010, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h13,  32'h0,        3'b000, 32'h00000012, 1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b001, 32'h00005678, 1'b0});
    vecs.push_back('{1'b1, 32'h11,  32'hFFFFFF80, 3'b000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b100, 32'h00000080, 1'b0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h12,  32'hAAAAAAAA, 3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'h12348078, 1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10,  32'hFFFFFFFF, 3'b011, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'h12348078, 1'b0});
    vecs.push_back('{1'b1, 32'h14,  32'h11223344, 3'b010, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h16,  32'hCAFEBEEF, 3'b001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        3'b010, 32'hBEEF3344, 1'b0});
    vecs.push_back('{1'b0, 32'h16,  32'h0,        3'b101, 32'h0000BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h16,  32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h15,  32'h0,        3'b001, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h15,  32'h0,        3'b001, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        3'b100, 32'h00000044, 1'b0});
    vecs.push_back('{1'b0, 32'h16,  32'h0,        3'b000, 32'hFFFFFFEF, 1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        3'b110, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h14,  32'h0,        3'b111, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h3FC, 32'h01020304, 3'b010, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h3FF, 32'h0000009A, 3'b000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        3'b010, 32'h9A020304, 1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        3'b010, 32'hBEEF3344, 1'b0});
    vecs.push_back('{1'b1, 32'h20,  32'h55AA55AA, 3'b010, 32'h0,        1'b0});

    foreach (vecs[i]) transact($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: resp_ready low for 5 cycles, req_valid held high with new fields
    drive(1'b0, 32'h10, 32'h0, 3'b010);
    @(negedge clk);
    drive(1'b1, 32'h14, 32'hFFFFFFFF, 3'b010);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("stall%0d rdata", c), resp_rdata, 32'h12348078);
      check($sformatf("stall%0d err", c), 32'(resp_err), 32'd0);
      check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 32'h14, 32'h0, 3'b010);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post-hs req_ready", 32'(req_ready), 32'd1);
    check("post-hs resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("held req accepted", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("held req valid", 32'(resp_valid), 32'd1);
    check("held req rdata", resp_rdata, 32'hBEEF3344);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset on the edge after acceptance aborts the store
    drive(1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort req_ready", 32'(req_ready), 32'd1);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (resp_valid) seen = 1'b1;
        @(negedge clk);
      end
      check("abort no resp_valid", 32'(seen), 32'd0);
    end
    transact("after abort", '{1'b0, 32'h20, 32'h0, 3'b010, 32'h55AA55AA, 1'b0});

    // Reset while holding an error response clears the outputs
    drive(1'b0, 32'h12, 32'h0, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("err resp held", 32'(resp_err), 32'd1);
    reset      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    resp_ready = 1'b0;
    check("rst in RESP valid", 32'(resp_valid), 32'd0);
    check("rst in RESP err", 32'(resp_err), 32'd0);
    check("rst in RESP ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
